// File: rtl/uart_receive_datapath.sv
// UART receive datapath: input synchroniser, 3-sample majority vote, frame
// shift register and counter, receive buffer and sticky line-status flags.
module uart_receive_datapath #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       uart_rxd,
   input  logic [1:0] wls,
   input  logic       pen,
   input  logic       eps,
   input  logic       voting_shift_en,
   input  logic       receive_shift_en,
   input  logic       receive_frame_counter_en,
   input  logic       receive_frame_counter_clear,
   input  logic       error_check,
   input  logic       receive_load_en,
   input  logic       rbr_read,
   input  logic       lsr_read,
   output logic       rx_data,
   output logic       all_zero,
   output logic       receive_done,
   output logic [7:0] rbr,
   output logic       dr,
   output logic       oe,
   output logic       pe,
   output logic       fe,
   output logic       bi
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   rxd_s;
   logic [2:0]             vote;
   logic [3:0]             cnt;
   logic [9:0]             sh;
   logic [9:0]             f;
   logic [3:0]             nd;
   logic [3:0]             flen;
   logic [3:0]             shamt;
   logic [3:0]             stop_idx;
   logic [7:0]             data_mask;
   logic [7:0]             data;
   logic                   parity_bit;
   logic                   stop_bit;
   logic                   perr;
   logic                   oe_set;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], uart_rxd};
      end
   end

   assign rxd_s = sync[SYNC_STAGES-1];

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         vote <= 3'b111;
      end else if (voting_shift_en) begin
         vote <= {vote[1:0], rxd_s};
      end
   end

   assign rx_data = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);

   // Frame geometry follows the live line configuration.
   assign nd        = 4'd5 + {2'b00, wls};
   assign flen      = nd + {3'b000, pen} + 4'd1;
   assign shamt     = 4'd10 - flen;
   assign stop_idx  = nd + {3'b000, pen};
   assign data_mask = 8'hFF >> (2'd3 - wls);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt <= 4'd0;
      end else if (receive_frame_counter_clear) begin
         cnt <= 4'd0;
      end else if (receive_frame_counter_en && (cnt != 4'hF)) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign receive_done = (cnt == flen);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sh <= 10'd0;
      end else if (receive_shift_en) begin
         sh <= {rx_data, sh[9:1]};
      end
   end

   // Zero-filled right shift leaves only the frame bits, so f==0 covers them all.
   assign f          = sh >> shamt;
   assign all_zero   = (f == 10'd0);
   assign data       = f[7:0] & data_mask;
   assign parity_bit = f[nd];
   assign stop_bit   = f[stop_idx];
   assign perr       = pen & (^data ^ parity_bit ^ ~eps);

   assign oe_set = receive_load_en & dr & ~rbr_read;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rbr <= 8'h00;
         dr  <= 1'b0;
      end else begin
         if (receive_load_en) begin
            rbr <= data;
            dr  <= 1'b1;
         end else if (rbr_read) begin
            dr  <= 1'b0;
         end
      end
   end

   // Set terms are OR-ed after the clear so a coincident set wins.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         oe <= 1'b0;
         pe <= 1'b0;
         fe <= 1'b0;
         bi <= 1'b0;
      end else begin
         oe <= (oe & ~lsr_read) | oe_set;
         pe <= (pe & ~lsr_read) | (error_check & perr);
         fe <= (fe & ~lsr_read) | (error_check & ~stop_bit);
         bi <= (bi & ~lsr_read) | (error_check & all_zero);
      end
   end

endmodule

// File: tb/tb_uart_receive_datapath.sv
// Directed bench for uart_receive_datapath: frames are driven through the
// synchroniser and vote path, then buffer and flag results are checked.
module tb_uart_receive_datapath;

   logic       pclk = 1'b0;
   logic       presetn;
   logic       uart_rxd;
   logic [1:0] wls;
   logic       pen;
   logic       eps;
   logic       voting_shift_en;
   logic       receive_shift_en;
   logic       receive_frame_counter_en;
   logic       receive_frame_counter_clear;
   logic       error_check;
   logic       receive_load_en;
   logic       rbr_read;
   logic       lsr_read;
   logic       rx_data;
   logic       all_zero;
   logic       receive_done;
   logic [7:0] rbr;
   logic       dr, oe, pe, fe, bi;

   int checks   = 0;
   int failures = 0;

   always #5 pclk = ~pclk;

   uart_receive_datapath #(.SYNC_STAGES(2)) dut (
      .pclk                        (pclk),
      .presetn                     (presetn),
      .uart_rxd                    (uart_rxd),
      .wls                         (wls),
      .pen                         (pen),
      .eps                         (eps),
      .voting_shift_en             (voting_shift_en),
      .receive_shift_en            (receive_shift_en),
      .receive_frame_counter_en    (receive_frame_counter_en),
      .receive_frame_counter_clear (receive_frame_counter_clear),
      .error_check                 (error_check),
      .receive_load_en             (receive_load_en),
      .rbr_read                    (rbr_read),
      .lsr_read                    (lsr_read),
      .rx_data                     (rx_data),
      .all_zero                    (all_zero),
      .receive_done                (receive_done),
      .rbr                         (rbr),
      .dr                          (dr),
      .oe                          (oe),
      .pe                          (pe),
      .fe                          (fe),
      .bi                          (bi)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic vote_bit(input logic b);
      uart_rxd = b;
      repeat (3) tick();
      voting_shift_en = 1'b1;
      tick();
      voting_shift_en = 1'b0;
   endtask

   // Three identical votes, then shift the voted bit into the frame.
   task automatic send_bit(input logic b);
      vote_bit(b);
      vote_bit(b);
      vote_bit(b);
      receive_shift_en         = 1'b1;
      receive_frame_counter_en = 1'b1;
      tick();
      receive_shift_en         = 1'b0;
      receive_frame_counter_en = 1'b0;
   endtask

   task automatic shift_frame(input string tag, input logic [9:0] bits, input int n,
                              input bit do_clear);
      if (do_clear) begin
         receive_frame_counter_clear = 1'b1;
         tick();
         receive_frame_counter_clear = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         send_bit(bits[i]);
         if (i == n - 2) chk({tag, "_done_before_last"}, {7'd0, receive_done}, 8'd0);
      end
      chk({tag, "_done_at_flen"}, {7'd0, receive_done}, 8'd1);
   endtask

   task automatic do_load(input bit rd);
      error_check     = 1'b1;
      receive_load_en = 1'b1;
      rbr_read        = rd;
      tick();
      error_check     = 1'b0;
      receive_load_en = 1'b0;
      rbr_read        = 1'b0;
   endtask

   task automatic pulse_lsr_read();
      lsr_read = 1'b1;
      tick();
      lsr_read = 1'b0;
   endtask

   task automatic pulse_rbr_read();
      rbr_read = 1'b1;
      tick();
      rbr_read = 1'b0;
   endtask

   initial begin
      presetn                     = 1'b0;
      uart_rxd                    = 1'b1;
      wls                         = 2'b11;
      pen                         = 1'b0;
      eps                         = 1'b0;
      voting_shift_en             = 1'b0;
      receive_shift_en            = 1'b0;
      receive_frame_counter_en    = 1'b0;
      receive_frame_counter_clear = 1'b0;
      error_check                 = 1'b0;
      receive_load_en             = 1'b0;
      rbr_read                    = 1'b0;
      lsr_read                    = 1'b0;
      repeat (3) tick();

      chk("rst_rx_data",      {7'd0, rx_data},      8'd1);
      chk("rst_all_zero",     {7'd0, all_zero},     8'd1);
      chk("rst_receive_done", {7'd0, receive_done}, 8'd0);
      chk("rst_rbr",          rbr,                  8'h00);
      chk("rst_flags",        {3'd0, dr, oe, pe, fe, bi}, 8'h00);
      presetn = 1'b1;
      tick();

      // 8N1 0xA5, stop=1
      wls = 2'b11; pen = 1'b0;
      shift_frame("a5", {1'b0, 1'b1, 8'hA5}, 9, 1'b1);
      do_load(1'b0);
      chk("a5_rbr", rbr, 8'hA5);
      chk("a5_dr",  {7'd0, dr}, 8'd1);
      chk("a5_flags", {4'd0, oe, pe, fe, bi}, 8'h00);
      pulse_rbr_read();
      chk("a5_dr_cleared", {7'd0, dr}, 8'd0);

      // 7E1 0x41 with parity bit 1: three ones in data+parity -> parity error
      wls = 2'b10; pen = 1'b1; eps = 1'b1;
      shift_frame("e7", {1'b0, 1'b1, 1'b1, 7'h41}, 9, 1'b1);
      do_load(1'b0);
      chk("e7_rbr", rbr, 8'h41);
      chk("e7_pe",  {7'd0, pe}, 8'd1);
      chk("e7_fe",  {7'd0, fe}, 8'd0);
      chk("e7_oe",  {7'd0, oe}, 8'd0);
      pulse_lsr_read();
      chk("e7_pe_cleared", {7'd0, pe}, 8'd0);
      pulse_rbr_read();

      // Break: 8N1, all nine bits zero
      wls = 2'b11; pen = 1'b0; eps = 1'b0;
      shift_frame("brk", 10'd0, 9, 1'b1);
      chk("brk_all_zero", {7'd0, all_zero}, 8'd1);
      do_load(1'b0);
      chk("brk_bi",  {7'd0, bi}, 8'd1);
      chk("brk_fe",  {7'd0, fe}, 8'd1);
      chk("brk_pe",  {7'd0, pe}, 8'd0);
      chk("brk_rbr", rbr, 8'h00);
      chk("brk_dr",  {7'd0, dr}, 8'd1);
      pulse_lsr_read();
      chk("brk_flags_cleared", {4'd0, oe, pe, fe, bi}, 8'h00);
      pulse_rbr_read();

      // Overrun: two loads without an intervening read
      shift_frame("ov1", {1'b0, 1'b1, 8'h11}, 9, 1'b1);
      do_load(1'b0);
      chk("ov1_oe", {7'd0, oe}, 8'd0);
      shift_frame("ov2", {1'b0, 1'b1, 8'h22}, 9, 1'b1);
      do_load(1'b0);
      chk("ov2_oe",  {7'd0, oe}, 8'd1);
      chk("ov2_rbr", rbr, 8'h22);
      chk("ov2_dr",  {7'd0, dr}, 8'd1);
      pulse_lsr_read();
      chk("ov2_oe_cleared", {7'd0, oe}, 8'd0);
      shift_frame("ov3", {1'b0, 1'b1, 8'h33}, 9, 1'b1);
      do_load(1'b1);
      chk("ov3_oe_read_same_cycle", {7'd0, oe}, 8'd0);
      chk("ov3_rbr", rbr, 8'h33);
      chk("ov3_dr_set_wins", {7'd0, dr}, 8'd1);
      shift_frame("ov4", {1'b0, 1'b1, 8'h44}, 9, 1'b1);
      do_load(1'b0);
      chk("ov4_oe", {7'd0, oe}, 8'd1);

      // Vote glitch: 1,0,1 -> 1 and 0,1,0 -> 0
      vote_bit(1'b1);
      vote_bit(1'b0);
      vote_bit(1'b1);
      chk("vote_101", {7'd0, rx_data}, 8'd1);
      vote_bit(1'b0);
      vote_bit(1'b1);
      vote_bit(1'b0);
      chk("vote_010", {7'd0, rx_data}, 8'd0);

      // Async reset after four shifts of a frame
      receive_frame_counter_clear = 1'b1;
      tick();
      receive_frame_counter_clear = 1'b0;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      #2 presetn = 1'b0;
      #1;
      chk("arst_flags", {3'd0, dr, oe, pe, fe, bi}, 8'h00);
      chk("arst_rbr", rbr, 8'h00);
      chk("arst_receive_done", {7'd0, receive_done}, 8'd0);
      chk("arst_rx_data", {7'd0, rx_data}, 8'd1);
      tick();
      presetn = 1'b1;
      tick();
      // No counter clear: done at the 9th enable proves cnt restarted from 0
      shift_frame("post", {1'b0, 1'b1, 8'h5A}, 9, 1'b0);
      do_load(1'b0);
      chk("post_rbr", rbr, 8'h5A);
      chk("post_dr",  {7'd0, dr}, 8'd1);
      chk("post_flags", {4'd0, oe, pe, fe, bi}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
